mux_stream_sequencer: RTL and testbench
=======================================

MUX_STREAM_SEQUENCER -- requirements
Module: mux_stream_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: width of every data word.
REQ-002 SHALL have parameter NUM_SRC, default 12: number of mux sources walked per pass (2..16).
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO depth in words (power of 2, >=2).
REQ-004 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1: begin a pass; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1: synchronous cancel of pass and FIFO flush.
REQ-008 SHALL have port mux_sel  output  4: select driven to upstream 12-to-1 mux.
REQ-009 SHALL have port mux_data  input  WORD_SIZE: combinational mux output for current mux_sel.
REQ-010 SHALL have port out_data  output  WORD_SIZE: FIFO head word.
REQ-011 SHALL have port out_valid  output  1: FIFO non-empty.
REQ-012 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-013 SHALL have port busy  output  1: high in RUN or DRAIN.
REQ-014 SHALL have port done  output  1: one-cycle pulse at pass completion.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE: mux_sel = 0; start=1 -> RUN next cycle, sel counter = 0.
REQ-017 RUN: each cycle with push enabled, mux_data SHALL be written to FIFO tail and sel counter incremented.
REQ-018 Push enabled = in RUN and (FIFO count < DEPTH or pop in same cycle).
REQ-019 Push disabled (full, no pop): sel counter and mux_sel SHALL hold; no word lost or duplicated.
REQ-020 Push of word NUM_SRC-1 SHALL transition RUN -> DRAIN; sel counter wraps to 0.
REQ-021 DRAIN: no pushes; FIFO empty (count 0 after any pop this cycle) -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; start in DONE ignored.
REQ-023 mux_sel SHALL equal the registered sel counter (no combinational path from inputs).
REQ-024 Pop = out_valid and out_ready; head advances next cycle; out_data stable while out_valid and not out_ready.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; FIFO ordering strictly first-in-first-out.
REQ-026 out_valid SHALL be count != 0; out_data when empty is don't-care but SHALL not be X after reset (reads zeroed storage).
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 abort=1 in any state SHALL next cycle: state IDLE, sel 0, FIFO count 0, out_valid 0, done 0; abort has priority over start, push and pop.
REQ-029 Words per pass SHALL be exactly NUM_SRC in sel order 0..NUM_SRC-1.
REQ-030 No arithmetic on data; words pass bit-exact.

Reset
REQ-031 reset_n=0 SHALL immediately force: state IDLE, mux_sel 0, FIFO pointers and count 0, out_valid 0, busy 0, done 0, FIFO storage 0.
REQ-032 Reset asserted mid-pass SHALL discard all buffered words; no done pulse after release.
REQ-033 First start SHALL be honoured on the first rising edge after reset_n deasserts.

Verification
REQ-034 Source i drives 16'h0A00+i, out_ready=1, pulse start -> 12 words 0x0A00..0x0A0B in order, busy 13 cycles, done one cycle after last pop.
REQ-035 out_ready=0 throughout, start -> FIFO fills with 0x0A00..0x0A03, mux_sel holds 4, out_valid=1, out_data 0x0A00 stable; release ready -> remaining 8 words follow, none lost.
REQ-036 FIFO full, out_ready=1 for one cycle -> simultaneous push/pop, count stays 4, mux_sel 4->5.
REQ-037 abort at third push -> next cycle out_valid=0, mux_sel=0, busy=0, no done; new start gives full 12-word pass.
REQ-038 reset_n low for one cycle mid-DRAIN -> outputs zero immediately, no done; start repeated during RUN -> ignored, exactly 12 words.

Source files
------------

// File: rtl/mux_stream_sequencer.sv
// rtl/mux_stream_sequencer.sv - walks an upstream mux across NUM_SRC sources and streams the words out through a small FIFO
module mux_stream_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_SRC   = 12,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [3:0]           mux_sel,
   input  logic [WORD_SIZE-1:0] mux_data,
   output logic [WORD_SIZE-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);
   localparam logic [3:0]    LAST_SEL   = 4'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t               state;
   logic [3:0]           sel;
   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [CW-1:0]        count;
   logic                 pop;
   logic                 push;
   logic                 drain_empty;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a word when it is being read.
   assign out_valid   = (count != '0);
   assign out_data    = mem[rd_ptr];
   assign pop         = out_valid & out_ready;
   assign push        = (state == ST_RUN) && ((count < FULL_COUNT) || pop);
   assign drain_empty = (count == '0) || ((count == ONE_COUNT) && pop);
   assign mux_sel     = sel;

   // FIFO storage, pointers and occupancy; abort flushes without touching stored words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (abort) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= mux_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Pass sequencing: select counter, state and the registered busy/done flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         sel   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (abort) begin
         state <= ST_IDLE;
         sel   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= ST_RUN;
                  sel   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (push) begin
                  if (sel == LAST_SEL) begin
                     sel   <= '0;
                     state <= ST_DRAIN;
                  end else begin
                     sel <= sel + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_empty) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               sel   <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_stream_sequencer.sv
// tb/tb_mux_stream_sequencer.sv - directed bench with queue-based reference model for mux_stream_sequencer
module tb_mux_stream_sequencer;

   localparam int WORD_SIZE = 16;
   localparam int NUM_SRC   = 12;
   localparam int DEPTH     = 4;

   localparam int P_IDLE  = 0;
   localparam int P_RUN   = 1;
   localparam int P_DRAIN = 2;
   localparam int P_DONE  = 3;

   logic                 clk       = 1'b0;
   logic                 reset_n   = 1'b0;
   logic                 start     = 1'b0;
   logic                 abort     = 1'b0;
   logic                 out_ready = 1'b0;
   logic [3:0]           mux_sel;
   logic [WORD_SIZE-1:0] mux_data;
   logic [WORD_SIZE-1:0] out_data;
   logic                 out_valid;
   logic                 busy;
   logic                 done;

   int vectors     = 0;
   int miscompares = 0;

   int                   m_phase = P_IDLE;
   int                   m_sel   = 0;
   logic [WORD_SIZE-1:0] m_q[$];

   logic [WORD_SIZE-1:0] rx[$];
   int                   busy_cnt     = 0;
   int                   done_cnt     = 0;
   int                   cyc          = 0;
   int                   last_pop_cyc = 0;
   int                   done_cyc     = 0;

   mux_stream_sequencer #(
      .WORD_SIZE(WORD_SIZE),
      .NUM_SRC  (NUM_SRC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .abort    (abort),
      .mux_sel  (mux_sel),
      .mux_data (mux_data),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .done     (done)
   );

   // free-running clock
   always #5 clk = ~clk;

   assign mux_data = 16'h0A00 + {12'h000, mux_sel};

   function automatic logic [WORD_SIZE-1:0] src_word(input int i);
      return 16'h0A00 + 16'(i);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_phase = P_IDLE;
      m_sel   = 0;
      m_q.delete();
   endtask

   // reference model: queue FIFO plus pass progress, advanced on each rising edge
   always @(posedge clk) begin
      int  ph;
      bit  m_pop;
      bit  m_push;
      cyc++;
      if (!reset_n || abort) begin
         model_clear();
      end else begin
         ph     = m_phase;
         m_pop  = (m_q.size() != 0) && out_ready;
         m_push = (ph == P_RUN) && ((m_q.size() < DEPTH) || m_pop);
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            m_q.push_back(src_word(m_sel));
            if (m_sel == NUM_SRC - 1) begin
               m_sel   = 0;
               m_phase = P_DRAIN;
            end else begin
               m_sel++;
            end
         end
         if (ph == P_IDLE && start) begin
            m_phase = P_RUN;
            m_sel   = 0;
         end else if (ph == P_DRAIN && m_q.size() == 0) begin
            m_phase = P_DONE;
         end else if (ph == P_DONE) begin
            m_phase = P_IDLE;
         end
      end
   end

   // asynchronous reset empties the model at once
   always @(negedge reset_n) model_clear();

   // every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin
      chk("mux_sel", {28'h0, mux_sel}, 32'(m_sel));
      chk("out_valid", {31'h0, out_valid}, {31'h0, (m_q.size() != 0)});
      chk("busy", {31'h0, busy}, {31'h0, (m_phase == P_RUN || m_phase == P_DRAIN)});
      chk("done", {31'h0, done}, {31'h0, (m_phase == P_DONE)});
      if (m_q.size() != 0) chk("out_data", {16'h0, out_data}, {16'h0, m_q[0]});
   end

   // collects accepted words and counts busy/done cycles
   always @(negedge clk) begin
      if (reset_n) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (out_valid && out_ready && !abort) begin
            rx.push_back(out_data);
            last_pop_cyc = cyc;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      rx.delete();
      busy_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      int k = 0;
      while (done_cnt == 0 && k < bound) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, {31'h0, (done_cnt != 0)}, 32'h1);
      tick(2);
   endtask

   task automatic check_pass(input string tag);
      chk({tag, "_word_count"}, 32'(rx.size()), 32'(NUM_SRC));
      for (int i = 0; i < rx.size() && i < NUM_SRC; i++) begin
         chk({tag, "_word"}, {16'h0, rx[i]}, {16'h0, src_word(i)});
      end
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'h1);
   endtask

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // directed stimulus
   initial begin
      tick(2);
      chk("rst_mux_sel", {28'h0, mux_sel}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_out_data", {16'h0, out_data}, 32'h0);
      reset_n = 1'b1;
      tick(2);

      // plain pass with downstream always ready
      clear_mon();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t2", 40);
      check_pass("t2");
      chk("t2_busy_cycles", 32'(busy_cnt), 32'd13);
      chk("t2_done_after_pop", 32'(done_cyc - last_pop_cyc), 32'h1);

      // backpressure: FIFO fills with the first four words
      clear_mon();
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(9);
      chk("t3_mux_sel_hold", {28'h0, mux_sel}, 32'h4);
      chk("t3_out_valid", {31'h0, out_valid}, 32'h1);
      chk("t3_out_data", {16'h0, out_data}, 32'h0A00);
      chk("t3_busy", {31'h0, busy}, 32'h1);
      out_ready = 1'b1;
      wait_done("t3", 40);
      check_pass("t3");

      // full FIFO with a single ready cycle: push and pop together
      clear_mon();
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(8);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t4_mux_sel_step", {28'h0, mux_sel}, 32'h5);
      chk("t4_out_data", {16'h0, out_data}, 32'h0A01);
      chk("t4_one_pop", 32'(rx.size()), 32'h1);
      tick(3);
      chk("t4_mux_sel_still", {28'h0, mux_sel}, 32'h5);
      out_ready = 1'b1;
      wait_done("t4", 40);
      check_pass("t4");

      // abort at the third push, then a fresh pass
      clear_mon();
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_out_valid", {31'h0, out_valid}, 32'h0);
      chk("t5_mux_sel", {28'h0, mux_sel}, 32'h0);
      chk("t5_busy", {31'h0, busy}, 32'h0);
      chk("t5_done", {31'h0, done}, 32'h0);
      chk("t5_words_before_abort", 32'(rx.size()), 32'h1);
      tick(5);
      chk("t5_no_done", 32'(done_cnt), 32'h0);
      clear_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t5", 40);
      check_pass("t5");

      // start held high during RUN is ignored
      clear_mon();
      out_ready = 1'b1;
      start = 1'b1;
      tick(5);
      start = 1'b0;
      wait_done("t6a", 40);
      check_pass("t6a");

      // reach DRAIN with buffered words, then a one-cycle reset
      clear_mon();
      out_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(7);
      out_ready = 1'b1;
      tick(8);
      out_ready = 1'b0;
      tick();
      chk("t6_drain_busy", {31'h0, busy}, 32'h1);
      chk("t6_drain_head", {16'h0, out_data}, 32'h0A08);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_mux_sel", {28'h0, mux_sel}, 32'h0);
      chk("t6_rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("t6_rst_busy", {31'h0, busy}, 32'h0);
      chk("t6_rst_done", {31'h0, done}, 32'h0);
      chk("t6_rst_out_data", {16'h0, out_data}, 32'h0);
      chk("t6_no_done_before_rst", 32'(done_cnt), 32'h0);
      @(posedge clk);
      #2;
      clear_mon();
      reset_n = 1'b1;
      start = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_start_after_rst", {31'h0, busy}, 32'h1);
      wait_done("t6b", 40);
      check_pass("t6b");
      chk("t6b_done_after_pop", 32'(done_cyc - last_pop_cyc), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
